// File: rtl/sap_apb_arbiter.sv
// sap_apb_arbiter: round-robin arbiter running single-beat APB transfers for up to four requesters.
// Build option: define SAP_APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC wait states.
//
// state   | meaning
// IDLE    | arbitrate; latch the winner's request fields
// SETUP   | PSELx driven, PENABLE low, one cycle
// ACCESS  | PENABLE high until PREADY (or timeout)
// RESP    | bus released, one-cycle rsp_valid to the granted requester
module sap_apb_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [3*NUM_REQ-1:0]          req_slave,
   input  logic [ADDR_W*NUM_REQ-1:0]     req_addr,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [DATA_W*NUM_REQ-1:0]     req_wdata,
   input  logic [(DATA_W/8)*NUM_REQ-1:0] req_strb,
   input  logic [3*NUM_REQ-1:0]          req_prot,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_W-1:0]             rsp_rdata,
   output logic                          rsp_err,
   output logic                          busy,
   output logic [2:0]                    PSELx,
   output logic                          PENABLE,
   output logic                          PWRITE,
   output logic [ADDR_W-1:0]             PADDR,
   output logic [DATA_W-1:0]             PWDATA,
   output logic [DATA_W/8-1:0]           PSTRB,
   output logic [2:0]                    PPROT,
   input  logic                          PREADY,
   input  logic                          PSLVERR,
   input  logic [DATA_W-1:0]             PRDATA
);

   localparam int STRB_W = DATA_W/8;

   if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_check
      $error("sap_apb_arbiter: NUM_REQ or TIMEOUT_CYC out of range");
   end

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

   state_t              state_q, state_d;
   logic [1:0]          last_grant_q, last_grant_d;
   logic [1:0]          grant_q, grant_d;
   logic [2:0]          slave_q, slave_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                pwrite_q, pwrite_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic [2:0]          pprot_q, pprot_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                grant_found;
   logic [1:0]          grant_idx;
`ifdef SAP_APB_TIMEOUT_EN
   logic [7:0]          cnt_q, cnt_d;
`endif

   // Search starts one past the last winner so nobody is served twice while others wait.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_grant_q;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!grant_found && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
            grant_found = 1'b1;
            grant_idx   = 2'((int'(last_grant_q) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      slave_d      = slave_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      pwrite_d     = pwrite_q;
      pstrb_d      = pstrb_q;
      pprot_d      = pprot_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
`ifdef SAP_APB_TIMEOUT_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               grant_d      = grant_idx;
               last_grant_d = grant_idx;
               slave_d      = req_slave[int'(grant_idx)*3 +: 3];
               paddr_d      = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
               pwdata_d     = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
               pwrite_d     = req_write[grant_idx];
               pstrb_d      = req_strb[int'(grant_idx)*STRB_W +: STRB_W];
               pprot_d      = req_prot[int'(grant_idx)*3 +: 3];
               if (req_slave[int'(grant_idx)*3 +: 3] != 3'b000) begin
                  state_d = ST_SETUP;
               end else begin
                  // Slave index 0 decodes to nothing: fail locally without a bus cycle.
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
`ifdef SAP_APB_TIMEOUT_EN
            cnt_d   = 8'd0;
`endif
         end
         ST_ACCESS: begin
            if (PREADY) begin
               state_d = ST_RESP;
               err_d   = PSLVERR;
               rdata_d = pwrite_q ? '0 : PRDATA;
            end
`ifdef SAP_APB_TIMEOUT_EN
            else if (cnt_q + 8'd1 == 8'(TIMEOUT_CYC)) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 2'(NUM_REQ-1);
         grant_q      <= 2'd0;
         slave_q      <= 3'b000;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pwrite_q     <= 1'b0;
         pstrb_q      <= '0;
         pprot_q      <= 3'b000;
         rdata_q      <= '0;
         err_q        <= 1'b0;
`ifdef SAP_APB_TIMEOUT_EN
         cnt_q        <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         slave_q      <= slave_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         pwrite_q     <= pwrite_d;
         pstrb_q      <= pstrb_d;
         pprot_q      <= pprot_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
`ifdef SAP_APB_TIMEOUT_EN
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign PSELx     = (state_q == ST_SETUP || state_q == ST_ACCESS) ? slave_q : 3'b000;
   assign PENABLE   = (state_q == ST_ACCESS);
   assign busy      = (state_q != ST_IDLE);
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign PWRITE    = pwrite_q;
   assign PSTRB     = pstrb_q;
   assign PPROT     = pprot_q;
   assign rsp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << grant_q) : '0;
   assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
   assign rsp_err   = (state_q == ST_RESP) ? err_q : 1'b0;

endmodule
